// File: rtl/alu_pipe.sv
// Pipelined ALU with a one-entry output register and a WIDTH-cycle shift-add multiplier.
// Non-MUL ops complete in one cycle; MUL parks the input side until its result is loaded.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_LSL  = 4'b0000;
    localparam logic [3:0] OP_LSR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_w, lsl_w, lsr_w, asr_w;
    logic [WIDTH-1:0] sub_w;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Shifts run on a WIDTH+1 vector so the extra bit catches the last bit shifted out;
    // a zero shift leaves that bit 0, which gives C=0 without a special case.
    always_comb begin
        sh    = in_b[SHW-1:0];
        add_w = {1'b0, in_a} + {1'b0, in_b};
        sub_w = in_a - in_b;
        lsl_w = {1'b0, in_a} << sh;
        lsr_w = {in_a, 1'b0} >> sh;
        asr_w = $signed({in_a, 1'b0}) >>> sh;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w;
                alu_c   = (in_a >= in_b);
                alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_NAND: alu_res = ~(in_a & in_b);
            OP_MOV:  alu_res = in_a;
            OP_CBZ:  alu_res[0] = (in_a == '0);
            OP_LSL: begin
                alu_res = lsl_w[WIDTH-1:0];
                alu_c   = lsl_w[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_w[WIDTH:1];
                alu_c   = lsr_w[0];
            end
            OP_ASR: begin
                alu_res = asr_w[WIDTH:1];
                alu_c   = asr_w[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        load        = 1'b0;
        load_res    = '0;
        load_c      = 1'b0;
        load_v      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = in_a;
                        mplier_d = in_b;
                        cnt_d    = '0;
                        op_d     = opcode;
                    end else begin
                        load     = 1'b1;
                        load_res = alu_res;
                        load_c   = alu_c;
                        load_v   = alu_v;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!out_valid_q || out_ready) begin
                    load     = 1'b1;
                    load_res = (op_q == OP_MUL) ? acc_q : '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A load wins over a consume on the same edge, keeping one op per cycle back-to-back.
        if (load) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            flags_d     = {load_res[WIDTH-1], (load_res == '0), load_c, load_v};
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases on WIDTH=32 and WIDTH=8 instances, then
// randomized traffic scored against an arithmetic reference model through a result queue.
module tb_alu_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, result;
    logic [3:0]  opcode, flags;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8, result8;
    logic [3:0]  opcode8, flags8;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t        exp_q[$];
    logic        mon_en = 1'b0;
    logic        stall_seen = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_flg;

    always #5 clock = ~clock;

    alu_pipe #(.WIDTH(32)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .opcode(opcode8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flags(flags8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: the opcode table evaluated with wide integer arithmetic.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        logic [63:0] wide;
        longint      sv;
        int          sh;
        logic        c, v;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        sh = int'(b[4:0]);
        case (op)
            4'b0010: begin
                wide = {32'd0, a} + {32'd0, b};
                r    = wide[31:0];
                c    = wide[32];
                sv   = longint'($signed(a)) + longint'($signed(b));
                v    = (sv != longint'($signed(r)));
            end
            4'b1010: begin
                r  = a - b;
                c  = (a >= b);
                sv = longint'($signed(a)) - longint'($signed(b));
                v  = (sv != longint'($signed(r)));
            end
            4'b0110: r = a & b;
            4'b0100: r = a | b;
            4'b1001: r = a ^ b;
            4'b0101: r = ~(a | b);
            4'b1100: r = ~(a & b);
            4'b1101: r = a;
            4'b0111: r = (a == 0) ? 32'd1 : 32'd0;
            4'b0000: begin
                r = a << sh;
                c = (sh != 0) ? a[32 - sh] : 1'b0;
            end
            4'b0001: begin
                r = a >> sh;
                c = (sh != 0) ? a[sh - 1] : 1'b0;
            end
            4'b1011: begin
                r = $signed(a) >>> sh;
                c = (sh != 0) ? a[sh - 1] : 1'b0;
            end
            4'b1110: begin
                wide = longint'(a) * longint'(b);
                r    = wide[31:0];
            end
            default: r = '0;
        endcase
        f = {r[31], (r == 0), c, v};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard: consumes are scored before the same edge's accept is queued.
    always @(negedge clock) begin
        if (mon_en) begin
            exp_t e;
            if (stall_seen) begin
                check("hold_valid", out_valid, 1);
                check("hold_res", result, held_res);
                check("hold_flags", flags, held_flg);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_res", result, e.res);
                    check("sb_flags", flags, e.flg);
                end
            end
            if (in_valid && in_ready) begin
                ref_alu(opcode, in_a, in_b, e.res, e.flg);
                exp_q.push_back(e);
            end
            stall_seen = out_valid && !out_ready;
            held_res   = result;
            held_flg   = flags;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov_seen;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        opcode     = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_a8      = '0;
        in_b8      = '0;
        opcode8    = '0;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);

        // ADD / SUB basics and overflow / carry corners
        in_valid = 1'b1; opcode = 4'b0010; in_a = 32'd15; in_b = 32'd15;
        step();
        check("add_valid", out_valid, 1);
        check("add_res", result, 32'd30);
        check("add_flags", flags, 4'b0000);
        opcode = 4'b1010; in_a = 32'd10; in_b = 32'd15;
        step();
        check("sub_res", result, 32'hFFFF_FFFB);
        check("sub_flags", flags, 4'b1000);
        opcode = 4'b0010; in_a = 32'h7FFF_FFFF; in_b = 32'd1;
        step();
        check("add_ovf_res", result, 32'h8000_0000);
        check("add_ovf_flags", flags, 4'b1001);
        in_a = 32'hFFFF_FFFF; in_b = 32'd1;
        step();
        check("add_carry_res", result, 32'h0);
        check("add_carry_flags", flags, 4'b0110);
        in_valid = 1'b0;
        step();
        check("consume_clears", out_valid, 0);

        // MUL latency: input side blocked for WIDTH+1 cycles, result on edge t+33
        in_valid = 1'b1; opcode = 4'b1110; in_a = 32'd1234; in_b = 32'd5678;
        step();
        in_valid = 1'b0;
        check("mul_busy_0", in_ready, 0);
        for (int k = 1; k <= 32; k++) begin
            step();
            check("mul_busy", in_ready, 0);
            check("mul_no_out", out_valid, 0);
        end
        step();
        check("mul_valid", out_valid, 1);
        check("mul_res", result, 32'd7006652);
        check("mul_flags", flags, 4'b0000);
        check("mul_ready_back", in_ready, 1);
        step();
        check("mul_consumed", out_valid, 0);

        // Backpressure: AND held, OR refused until the consumer takes AND
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'b0110; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_FFFF;
        step();
        check("and_res", result, 32'h00F0_1234);
        opcode = 4'b0100;
        #1;
        check("stall_in_ready", in_ready, 0);
        step();
        check("stall_valid", out_valid, 1);
        check("stall_res", result, 32'h00F0_1234);
        check("stall_in_ready2", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 1);
        step();
        check("or_valid", out_valid, 1);
        check("or_res", result, 32'hFFF0_FFFF);
        in_valid = 1'b0;
        step();
        check("or_consumed", out_valid, 0);

        // Reset mid-MUL discards the operation
        in_valid = 1'b1; opcode = 4'b1110; in_a = 32'd77; in_b = 32'd99;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_res", result, 0);
        check("midrst_flags", flags, 0);
        repeat (2) step();
        reset_n = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        ov_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid) ov_seen = 1'b1;
        end
        check("postrst_no_result", ov_seen, 0);

        // WIDTH=8 shift and NOR corners
        in_valid8 = 1'b1; opcode8 = 4'b0001; in_a8 = 8'h81; in_b8 = 8'h01;
        step();
        check("w8_lsr_res", result8, 8'h40);
        check("w8_lsr_flags", flags8, 4'b0010);
        opcode8 = 4'b1011;
        step();
        check("w8_asr_res", result8, 8'hC0);
        check("w8_asr_flags", flags8, 4'b1010);
        opcode8 = 4'b0101; in_a8 = 8'h0F; in_b8 = 8'hF0;
        step();
        check("w8_nor_res", result8, 8'h00);
        check("w8_nor_flags", flags8, 4'b0100);
        in_valid8 = 1'b0;

        // Randomized traffic with random backpressure
        mon_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            opcode    = 4'($urandom_range(0, 15));
            in_a      = pick();
            in_b      = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
        step();
        check("drain_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, never overridden.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  request accepted on a clock edge where in_valid && in_ready.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B; for shifts, in_b[SHW-1:0] is the shift amount.
REQ-009 opcode  input  4  operation select, per REQ-016.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result on a clock edge where out_valid && out_ready.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  4  {N,Z,C,V}.

Function
REQ-014 The block SHALL have states IDLE, MUL, DONE plus a single-entry output register (result, flags, out_valid).
REQ-015 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready), driven combinationally.
REQ-016 Opcode table: 0010 ADD a+b; 1010 SUB a-b; 0110 AND; 0100 OR; 1001 XOR; 0101 NOR ~(a|b); 1100 NAND ~(a&b); 1101 MOV a; 0111 CBZ result = (a==0) zero-extended; 0000 LSL a<<sh; 0001 LSR a>>sh logical; 1011 ASR arithmetic; 1110 MUL low WIDTH bits of a*b; other opcodes give result 0.
REQ-017 NOR and NAND SHALL be bitwise, all WIDTH bits.
REQ-018 A non-MUL op accepted at edge t SHALL load the output register at t, so out_valid is high after edge t; latency 1 cycle.
REQ-019 An accepted MUL SHALL latch a, b and opcode, enter MUL, and run one shift-add iteration per cycle for exactly WIDTH cycles.
REQ-020 After the last iteration the FSM SHALL go to DONE; from DONE it loads the output register and returns to IDLE on the first edge where !out_valid || out_ready.
REQ-021 With no stall, a MUL accepted at edge t SHALL produce out_valid after edge t+WIDTH+1.
REQ-022 If out_valid && !out_ready, result, flags and out_valid SHALL hold unchanged.
REQ-023 A consume and a new load on the same edge SHALL leave out_valid high with the new result, giving back-to-back throughput of 1 op per cycle for non-MUL ops.
REQ-024 A consume with no new load SHALL clear out_valid.
REQ-025 Flag N SHALL equal result[WIDTH-1]; Z SHALL equal (result==0) for every op.
REQ-026 C SHALL be the carry-out for ADD and the no-borrow flag (a>=b unsigned) for SUB.
REQ-027 C SHALL be the last bit shifted out for LSL/LSR/ASR with shift amount != 0, and 0 otherwise.
REQ-028 V SHALL be signed overflow for ADD and SUB, and 0 for all other ops.
REQ-029 A shift amount of 0 SHALL return a unchanged with C=0.
REQ-030 Input operands and opcode SHALL be ignored while in_ready is low.

Reset
REQ-031 reset_n low SHALL immediately force state=IDLE, out_valid=0, result=0, flags=0 and clear the iteration counter, including mid-MUL.
REQ-032 In-flight MUL operands SHALL be discarded on reset; no result is produced after release.
REQ-033 in_ready SHALL be high in the first cycle after reset release.

Verification
REQ-034 WIDTH=32, ADD 15+15 with out_ready=1 -> one cycle later result=30, flags=0000; then SUB 10-15 -> result=0xFFFFFFFB, flags N=1 C=0 V=0.
REQ-035 ADD 0x7FFFFFFF+1 -> result=0x80000000, N=1 V=1 C=0; ADD 0xFFFFFFFF+1 -> result=0, Z=1 C=1 V=0.
REQ-036 MUL 1234*5678 -> in_ready low for 33 cycles, result=7006652 at edge t+33, no other output change meanwhile.
REQ-037 out_ready=0 while issuing AND then OR -> AND result holds, in_ready=0, OR is not accepted; raise out_ready -> AND consumed, OR accepted on the same edge, OR result next cycle.
REQ-038 Assert reset_n low 10 cycles into a MUL -> out_valid=0, result=0 immediately; after release, no MUL result appears and in_ready=1.
REQ-039 Run with WIDTH=8: LSR 0x81 by 1 -> result=0x40, C=1; ASR 0x81 by 1 -> result=0xC0, N=1; NOR 0x0F,0xF0 -> result=0x00, Z=1.
